// File: rtl/bitonic_pair_loader_if.sv
// Stream bundle for the pair loader: element input stream and pair output
// stream towards the first posstage comparator.
interface bitonic_pair_loader_if #(
    parameter int W     = 16,
    parameter int CNT_W = 8
);
    // element stream (producer -> loader)
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;

    // pair stream (loader -> comparator)
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_pair;
    logic             out_direction;
    logic             out_last;
    logic             out_pad;
    logic [CNT_W-1:0] out_idx;

    // environment side: produces elements, consumes pairs
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_pair, out_direction, out_last, out_pad, out_idx
    );

    // loader side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_pair, out_direction, out_last, out_pad, out_idx
    );
endinterface

// File: rtl/bitonic_pair_loader.sv
// Serial-to-pair front end: packs two consecutive W-bit elements into one
// 2*W word {second, first}, tags it with a compare direction and a per-frame
// pair index, and pads an odd trailing element so the comparator always sees
// a full pair. All pair-side outputs are registered; the only combinational
// path is out_ready -> in_ready.
module bitonic_pair_loader #(
    parameter int           W        = 16,
    parameter logic [W-1:0] PAD      = {W{1'b1}},
    parameter logic         DIR_INIT = 1'b0,
    parameter logic         ALT_DIR  = 1'b1,
    parameter int           CNT_W    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    bitonic_pair_loader_if.slave    bus
);

    typedef enum logic [1:0] {
        S_LO  = 2'd0,   // waiting for the first element of a pair
        S_HI  = 2'd1,   // first element held, waiting for the second
        S_OUT = 2'd2    // pair registered and offered downstream
    } state_e;

    // Direction the next pair gets once the current one has been consumed.
    function automatic logic advance_dir(input logic cur);
        logic nxt;
        if (ALT_DIR) begin
            nxt = ~cur;
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    state_e             state_q,    state_d;
    logic [W-1:0]       lo_q,       lo_d;       // held first element, invisible until pair forms
    logic [2*W-1:0]     pair_q,     pair_d;
    logic               out_dir_q,  out_dir_d;  // direction captured with the pair
    logic               out_last_q, out_last_d;
    logic               out_pad_q,  out_pad_d;
    logic [CNT_W-1:0]   out_idx_q,  out_idx_d;  // index captured with the pair
    logic               dir_q,      dir_d;      // direction for the next pair to form
    logic [CNT_W-1:0]   idx_q,      idx_d;      // index for the next pair to form

    logic               in_ready_s;
    logic               in_fire_s;
    logic               out_fire_s;
    logic               form_full_s;
    logic               form_pad_s;

    // Handshakes, direction/index bookkeeping and next-state/pair formation.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        pair_d      = pair_q;
        out_dir_d   = out_dir_q;
        out_last_d  = out_last_q;
        out_pad_d   = out_pad_q;
        out_idx_d   = out_idx_q;
        dir_d       = dir_q;
        idx_d       = idx_q;
        form_full_s = 1'b0;
        form_pad_s  = 1'b0;

        in_ready_s  = (state_q != S_OUT) || bus.out_ready;
        in_fire_s   = bus.in_valid && in_ready_s;
        out_fire_s  = (state_q == S_OUT) && bus.out_ready;

        // Consuming a pair advances direction/index; a frame-closing pair
        // rearms both for the next frame. Updated values are used if a new
        // pair forms in the same cycle.
        if (out_fire_s) begin
            if (out_last_q) begin
                dir_d = DIR_INIT;
                idx_d = {CNT_W{1'b0}};
            end else begin
                dir_d = advance_dir(dir_q);
                idx_d = idx_q + CNT_W'(1'b1);
            end
        end else begin
            dir_d = dir_q;
            idx_d = idx_q;
        end

        case (state_q)
            S_LO: begin
                if (in_fire_s) begin
                    if (bus.in_last) begin
                        form_pad_s = 1'b1;
                    end else begin
                        lo_d    = bus.in_data;
                        state_d = S_HI;
                    end
                end else begin
                    state_d = S_LO;
                end
            end
            S_HI: begin
                if (in_fire_s) begin
                    form_full_s = 1'b1;
                end else begin
                    state_d = S_HI;
                end
            end
            S_OUT: begin
                if (out_fire_s) begin
                    if (in_fire_s) begin
                        if (bus.in_last) begin
                            form_pad_s = 1'b1;
                        end else begin
                            lo_d    = bus.in_data;
                            state_d = S_HI;
                        end
                    end else begin
                        state_d = S_LO;
                    end
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_LO;
            end
        endcase

        // Pair contents change only when a pair is formed.
        if (form_full_s) begin
            pair_d     = {bus.in_data, lo_q};
            out_pad_d  = 1'b0;
            out_last_d = bus.in_last;
        end else if (form_pad_s) begin
            pair_d     = {PAD, bus.in_data};
            out_pad_d  = 1'b1;
            out_last_d = 1'b1;
        end else begin
            pair_d     = pair_q;
            out_pad_d  = out_pad_q;
            out_last_d = out_last_q;
        end

        if (form_full_s || form_pad_s) begin
            out_dir_d = dir_d;
            out_idx_d = idx_d;
            state_d   = S_OUT;
        end else begin
            out_dir_d = out_dir_q;
            out_idx_d = out_idx_q;
        end
    end

    // State and pair registers; reset drops any half-collected pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LO;
            lo_q       <= {W{1'b0}};
            pair_q     <= {(2*W){1'b0}};
            out_dir_q  <= DIR_INIT;
            out_last_q <= 1'b0;
            out_pad_q  <= 1'b0;
            out_idx_q  <= {CNT_W{1'b0}};
            dir_q      <= DIR_INIT;
            idx_q      <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            lo_q       <= lo_d;
            pair_q     <= pair_d;
            out_dir_q  <= out_dir_d;
            out_last_q <= out_last_d;
            out_pad_q  <= out_pad_d;
            out_idx_q  <= out_idx_d;
            dir_q      <= dir_d;
            idx_q      <= idx_d;
        end
    end

    // Output drive from registered state.
    always_comb begin
        bus.in_ready      = in_ready_s;
        bus.out_valid     = (state_q == S_OUT);
        bus.out_pair      = pair_q;
        bus.out_direction = out_dir_q;
        bus.out_last      = out_last_q;
        bus.out_pad       = out_pad_q;
        bus.out_idx       = out_idx_q;
    end

endmodule

// File: tb/tb_bitonic_pair_loader.sv
// Bench for bitonic_pair_loader: directed element streams, expected pairs
// queued at issue time and popped by per-instance monitors.
module tb_bitonic_pair_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bitonic_pair_loader_if #(.W(16), .CNT_W(8)) b1();
    bitonic_pair_loader_if #(.W(16), .CNT_W(2)) b2();

    bitonic_pair_loader #(.W(16), .PAD(16'hFFFF), .DIR_INIT(1'b0), .ALT_DIR(1'b1), .CNT_W(8))
        u1 (.clk(clk), .rst(rst), .bus(b1.slave));

    bitonic_pair_loader #(.W(16), .PAD(16'hFFFF), .DIR_INIT(1'b0), .ALT_DIR(1'b0), .CNT_W(2))
        u2 (.clk(clk), .rst(rst), .bus(b2.slave));

    int n_cmp  = 0;
    int n_bad  = 0;
    int stalls = 0;
    logic [63:0] q1[$];
    logic [63:0] q2[$];
    logic [1:0]  idx_tab [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] e1(input logic [31:0] p, input logic d, input logic l,
                                       input logic pd, input logic [7:0] ix);
        return {21'd0, p, d, l, pd, ix};
    endfunction

    function automatic logic [63:0] e2(input logic [31:0] p, input logic d, input logic l,
                                       input logic pd, input logic [1:0] ix);
        return {27'd0, p, d, l, pd, ix};
    endfunction

    // Offer one element to u1 and wait (bounded) until it is accepted.
    task automatic send1(input logic [15:0] d, input logic l);
        int w;
        w = 0;
        b1.in_valid = 1'b1;
        b1.in_data  = d;
        b1.in_last  = l;
        while (!b1.in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!b1.in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: element %h not accepted after %0d cycles", d, w);
        end
        stalls += w;
        @(posedge clk);
        @(negedge clk);
        b1.in_valid = 1'b0;
    endtask

    // Monitor for u1: every consumed pair is checked against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst == 1'b0 && b1.out_valid && b1.out_ready) begin
                if (q1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL u1_unexpected: got pair %h with nothing expected", b1.out_pair);
                end else begin
                    chk("u1_pair", e1(b1.out_pair, b1.out_direction, b1.out_last, b1.out_pad, b1.out_idx),
                        q1.pop_front());
                end
            end
        end
    end

    // Monitor for u2.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst == 1'b0 && b2.out_valid && b2.out_ready) begin
                if (q2.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL u2_unexpected: got pair %h with nothing expected", b2.out_pair);
                end else begin
                    chk("u2_pair", e2(b2.out_pair, b2.out_direction, b2.out_last, b2.out_pad, b2.out_idx),
                        q2.pop_front());
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        logic [15:0] va;
        logic [15:0] vb;
        int w;

        b1.in_valid = 1'b0; b1.in_data = 16'd0; b1.in_last = 1'b0; b1.out_ready = 1'b0;
        b2.in_valid = 1'b0; b2.in_data = 16'd0; b2.in_last = 1'b0; b2.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_hs", {62'd0, b1.out_valid, b1.in_ready}, 64'd1);
        chk("reset_outs", e1(b1.out_pair, b1.out_direction, b1.out_last, b1.out_pad, b1.out_idx),
            e1(32'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        @(negedge clk);

        // 1: 1,2,3,4 back to back
        b1.out_ready = 1'b1;
        stalls = 0;
        send1(16'h0001, 1'b0);
        q1.push_back(e1(32'h0002_0001, 1'b0, 1'b0, 1'b0, 8'd0));
        send1(16'h0002, 1'b0);
        send1(16'h0003, 1'b0);
        q1.push_back(e1(32'h0004_0003, 1'b1, 1'b1, 1'b0, 8'd1));
        send1(16'h0004, 1'b1);
        chk("t1_no_stall", 64'(stalls), 64'd0);

        // 2: odd frame 5,6,7 -> padded last pair
        send1(16'h0005, 1'b0);
        q1.push_back(e1(32'h0006_0005, 1'b0, 1'b0, 1'b0, 8'd0));
        send1(16'h0006, 1'b0);
        q1.push_back(e1(32'hFFFF_0007, 1'b1, 1'b1, 1'b1, 8'd1));
        send1(16'h0007, 1'b1);
        repeat (2) @(negedge clk);

        // 3: backpressure on {B,A}; new frame so dir0 idx0
        b1.out_ready = 1'b0;
        send1(16'h000A, 1'b0);
        q1.push_back(e1(32'h000B_000A, 1'b0, 1'b0, 1'b0, 8'd0));
        send1(16'h000B, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {22'd0, b1.out_valid, b1.in_ready, b1.out_direction, b1.out_idx, b1.out_pair},
                {22'd0, 1'b1, 1'b0, 1'b0, 8'd0, 32'h000B_000A});
            @(negedge clk);
        end
        b1.out_ready = 1'b1;
        @(negedge clk);
        chk("t3_released", {63'd0, b1.out_valid}, 64'd0);

        // 4: pair emitted the same cycle the next element is taken
        stalls = 0;
        send1(16'h00A4, 1'b0);
        q1.push_back(e1(32'h00B4_00A4, 1'b1, 1'b0, 1'b0, 8'd1));
        send1(16'h00B4, 1'b0);
        send1(16'h00C4, 1'b0);
        q1.push_back(e1(32'h00D4_00C4, 1'b0, 1'b1, 1'b0, 8'd2));
        send1(16'h00D4, 1'b1);
        chk("t4_no_stall", 64'(stalls), 64'd0);

        // 5: reset with 9 held as a half pair
        send1(16'h0011, 1'b0);
        q1.push_back(e1(32'h0022_0011, 1'b0, 1'b0, 1'b0, 8'd0));
        send1(16'h0022, 1'b0);
        send1(16'h0009, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_rst_hs", {62'd0, b1.out_valid, b1.in_ready}, 64'd1);
        chk("t5_rst_outs", e1(b1.out_pair, b1.out_direction, b1.out_last, b1.out_pad, b1.out_idx),
            e1(32'd0, 1'b0, 1'b0, 1'b0, 8'd0));
        @(negedge clk);
        rst = 1'b0;
        send1(16'h0001, 1'b0);
        q1.push_back(e1(32'h0002_0001, 1'b0, 1'b1, 1'b0, 8'd0));
        send1(16'h0002, 1'b1);

        // 6: fixed direction, 2-bit index wrap, 10 pairs without last
        b2.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            va = 16'(16'h0100 + i);
            if (i % 2 == 1) begin
                vb = 16'(16'h0100 + i - 1);
                q2.push_back(e2({va, vb}, 1'b0, 1'b0, 1'b0, idx_tab[i / 2]));
            end
            b2.in_valid = 1'b1;
            b2.in_data  = va;
            b2.in_last  = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        b2.in_valid = 1'b0;

        w = 0;
        while ((q1.size() != 0 || q2.size() != 0) && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("drain_q1", 64'(q1.size()), 64'd0);
        chk("drain_q2", 64'(q2.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
